fpu_issue: RTL

- Requester side of the FPU trig/okay handshake.
- Accepts one FP operation from the execute stage over a valid/ready interface and drives the FPU operand, op, length, trig and flush lines.
- Waits for okay, formats the 64-bit result (NaN-box or sign-extend for 32-bit ops), and presents it to writeback over valid/ready.
- Handles pipeline kill and an FPU watchdog timeout; exactly one operation is in flight at a time.

---
 rtl/fpu_issue_pkg.sv | 25 ++
 rtl/fpu_issue_if.sv | 48 ++++
 rtl/fpu_issue.sv | 126 ++++++++++++
 3 files changed

// File: rtl/fpu_issue_pkg.sv
// Shared types and result formatting for the FPU issue stage.
// Keeps the NaN-box and sign-extension rules in one place.
package fpu_issue_pkg;

  localparam int OP_W_DEF = 5;
  localparam logic [31:0] NAN_BOX = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // Single-precision results are NaN-boxed for the FP regfile, sign-extended for the integer regfile
  function automatic logic [63:0] fmt_result(input logic len_64, input logic int_dst,
                                             input logic [63:0] data);
    if (len_64)
      return data;
    else if (int_dst)
      return {{32{data[31]}}, data[31:0]};
    else
      return {NAN_BOX, data[31:0]};
  endfunction

endpackage

// File: rtl/fpu_issue_if.sv
// Execute-stage request, FPU trig/okay and writeback signals of the FPU issue stage.
// The slave modport is the issue stage itself; master is the surrounding pipeline and FPU.
interface fpu_issue_if #(
  parameter int OP_W = fpu_issue_pkg::OP_W_DEF
);

  logic            req_valid;
  logic            req_ready;
  logic            req_len_64;
  logic            req_int_dst;
  logic [OP_W-1:0] req_op;
  logic [4:0]      req_rd;
  logic [63:0]     req_src1;
  logic [63:0]     req_src2;
  logic            kill;

  logic            fpu_trig;
  logic            fpu_len_64;
  logic [OP_W-1:0] fpu_op;
  logic            fpu_flush;
  logic [63:0]     fpu_src1;
  logic [63:0]     fpu_src2;
  logic [63:0]     fpu_out;
  logic            fpu_okay;

  logic            wb_valid;
  logic            wb_ready;
  logic [4:0]      wb_rd;
  logic [63:0]     wb_data;

  logic            busy;
  logic            tmo_err;

  modport slave (
    input  req_valid, req_len_64, req_int_dst, req_op, req_rd, req_src1, req_src2, kill,
    input  fpu_out, fpu_okay, wb_ready,
    output req_ready, fpu_trig, fpu_len_64, fpu_op, fpu_flush, fpu_src1, fpu_src2,
    output wb_valid, wb_rd, wb_data, busy, tmo_err
  );

  modport master (
    output req_valid, req_len_64, req_int_dst, req_op, req_rd, req_src1, req_src2, kill,
    output fpu_out, fpu_okay, wb_ready,
    input  req_ready, fpu_trig, fpu_len_64, fpu_op, fpu_flush, fpu_src1, fpu_src2,
    input  wb_valid, wb_rd, wb_data, busy, tmo_err
  );

endinterface

// File: rtl/fpu_issue.sv
// Requester side of the FPU trig/okay handshake: issues one op at a time,
// waits for okay or watchdog expiry, and hands the formatted result to writeback.
module fpu_issue
  import fpu_issue_pkg::*;
#(
  parameter int OP_W    = OP_W_DEF,
  parameter int TMO_CYC = 64
) (
  input  logic       clk,
  input  logic       rst,
  fpu_issue_if.slave bus
);

  localparam int CNT_W = (TMO_CYC > 2) ? $clog2(TMO_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TMO_CYC - 1);

  state_t          state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic            trig_q;
  logic            len_q;
  logic            int_dst_q;
  logic [OP_W-1:0] op_q;
  logic [4:0]      rd_q;
  logic [63:0]     src1_q;
  logic [63:0]     src2_q;
  logic [63:0]     data_q;

  logic            req_ready_c;
  logic            accept;
  logic            capture;
  logic            flush;
  logic            tmo;

  // rst gates ready so every output reads zero while reset is held
  assign req_ready_c = !rst && !bus.kill &&
                       ((state_q == IDLE) || ((state_q == RESP) && bus.wb_ready));
  assign accept      = bus.req_valid && req_ready_c;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    flush   = 1'b0;
    tmo     = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = WAIT;
          cnt_d   = '0;
        end
      end
      WAIT: begin
        // okay is not believed in the trig cycle; kill outranks both okay and timeout
        if (bus.kill) begin
          flush   = 1'b1;
          state_d = IDLE;
        end else if (bus.fpu_okay && !trig_q) begin
          capture = 1'b1;
          state_d = RESP;
        end else if (cnt_q == CNT_LAST) begin
          flush   = 1'b1;
          tmo     = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP: begin
        if (bus.kill) begin
          state_d = IDLE;
        end else if (bus.wb_ready) begin
          if (accept) begin
            state_d = WAIT;
            cnt_d   = '0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      trig_q    <= 1'b0;
      len_q     <= 1'b0;
      int_dst_q <= 1'b0;
      op_q      <= '0;
      rd_q      <= '0;
      src1_q    <= '0;
      src2_q    <= '0;
      data_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      trig_q  <= accept;
      if (accept) begin
        len_q     <= bus.req_len_64;
        int_dst_q <= bus.req_int_dst;
        op_q      <= bus.req_op;
        rd_q      <= bus.req_rd;
        src1_q    <= bus.req_src1;
        src2_q    <= bus.req_src2;
      end
      if (capture)
        data_q <= fmt_result(len_q, int_dst_q, bus.fpu_out);
    end
  end

  assign bus.req_ready  = req_ready_c;
  assign bus.fpu_trig   = trig_q;
  assign bus.fpu_len_64 = len_q;
  assign bus.fpu_op     = op_q;
  assign bus.fpu_src1   = src1_q;
  assign bus.fpu_src2   = src2_q;
  assign bus.fpu_flush  = flush;
  assign bus.tmo_err    = tmo;
  assign bus.wb_valid   = (state_q == RESP);
  assign bus.wb_rd      = rd_q;
  assign bus.wb_data    = data_q;
  assign bus.busy       = (state_q != IDLE);

endmodule
